// File: rtl/id_branch_predictor.sv
// id_branch_predictor: direct-mapped branch target buffer with saturating
// direction counters. IF looks it up combinationally to steer the next PC.
// ID trains it on resolved beq/bne and produces the redirect that replaces
// the bare pc_src for the IF mux and the IF/ID flush.
// Optional feature macro: BP_STATS_EN (resolved-branch / mispredict counters).
module id_branch_predictor #(
    parameter int ENTRIES    = 64,
    parameter int CTR_BITS   = 2,
    parameter int INDEX_BITS = $clog2(ENTRIES)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_if_pc,
    output logic        o_if_predict_taken,
    output logic [31:0] o_if_pred_target,
    input  logic        i_id_valid,
    input  logic        i_stall,
    input  logic [31:0] i_id_pc,
    input  logic        i_id_taken,
    input  logic [31:0] i_id_target,
    input  logic        i_id_predicted,
    input  logic [31:0] i_id_pred_target,
    output logic        o_id_mispredict,
    output logic [31:0] o_id_redirect_pc,
    output logic [31:0] o_stat_branches,
    output logic [31:0] o_stat_mispredicts
);

    localparam int TAG_W = 32 - INDEX_BITS - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
    localparam logic [CTR_BITS-1:0] CTR_ONE     = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic                  valid_q  [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [31:0]           target_q [ENTRIES];
    logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]      if_tag;
    logic                  if_hit;
    logic [INDEX_BITS-1:0] id_idx;
    logic [TAG_W-1:0]      id_tag;
    logic                  id_hit;
    logic                  upd;
    logic                  unused_pc_bits;

    function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
        return (c == CTR_MAX) ? c : c + CTR_ONE;
    endfunction

    function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
        return (c == '0) ? c : c - CTR_ONE;
    endfunction

    // The byte offset within a word never selects an entry.
    assign unused_pc_bits = ^{i_if_pc[1:0], i_id_pc[1:0]};

    assign if_idx = i_if_pc[INDEX_BITS+1:2];
    assign if_tag = i_if_pc[31:INDEX_BITS+2];
    assign id_idx = i_id_pc[INDEX_BITS+1:2];
    assign id_tag = i_id_pc[31:INDEX_BITS+2];
    assign upd    = i_id_valid && !i_stall;

    // IF lookup; forced to zero while reset is held so stale contents never leak.
    always_comb begin
        if_hit             = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        id_hit             = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
        o_if_predict_taken = 1'b0;
        o_if_pred_target   = '0;
        if (!i_reset) begin
            o_if_predict_taken = if_hit && ctr_q[if_idx][CTR_BITS-1];
            o_if_pred_target   = target_q[if_idx];
        end
    end

    // ID resolution: wrong direction, or right "taken" with the wrong target.
    always_comb begin
        o_id_mispredict  = upd && ((i_id_predicted != i_id_taken) ||
                           (i_id_predicted && i_id_taken && (i_id_pred_target != i_id_target)));
        o_id_redirect_pc = i_id_taken ? i_id_target : i_id_pc + 32'd4;
    end

    // Table training from ID; a taken miss evicts whatever aliases the index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
        end else if (upd) begin
            if (id_hit) begin
                if (i_id_taken) begin
                    ctr_q[id_idx]    <= sat_inc(ctr_q[id_idx]);
                    target_q[id_idx] <= i_id_target;
                end else begin
                    ctr_q[id_idx] <= sat_dec(ctr_q[id_idx]);
                end
            end else if (i_id_taken) begin
                valid_q[id_idx]  <= 1'b1;
                tag_q[id_idx]    <= id_tag;
                target_q[id_idx] <= i_id_target;
                ctr_q[id_idx]    <= CTR_WEAK_T;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    // Saturating event counters for resolved branches and mispredicts.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else if (upd) begin
            if (stat_branches_q != 32'hFFFF_FFFF)
                stat_branches_q <= stat_branches_q + 32'd1;
            if (o_id_mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF))
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign o_stat_branches    = stat_branches_q;
    assign o_stat_mispredicts = stat_mispredicts_q;
`else
    assign o_stat_branches    = '0;
    assign o_stat_mispredicts = '0;
`endif

endmodule

// File: doc/id_branch_predictor.md
# id_branch_predictor

Parametrised branch predictor with a branch target buffer for the 5-stage MIPS pipeline. It is looked up combinationally from IF to steer the next PC. It is trained from ID, where beq/bne resolve, so IF can fetch the predicted path instead of always waiting for ID's pc_src. It also produces the ID-stage mispredict/redirect signal that replaces the bare pc_src for the IF mux and IF/ID flush.

## Interface
Parameters:
- ENTRIES, 64, number of table entries; power of two, ≥ 2.
- CTR_BITS, 2, saturating counter width; ≥ 1.
- INDEX_BITS, $clog2(ENTRIES), derived; do not override.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_if_pc  in  32  PC being fetched.
- o_if_predict_taken  out  1  lookup hit and counter MSB = 1.
- o_if_pred_target  out  32  stored target of the indexed entry.
- i_id_valid  in  1  a conditional branch is resolved in ID this cycle.
- i_stall  in  1  ID stall (hazard unit); blocks training.
- i_id_pc  in  32  PC of the branch in ID.
- i_id_taken  in  1  resolved direction (branch AND comparator result).
- i_id_target  in  32  resolved target (PC+4 + offset<<2).
- i_id_predicted  in  1  prediction carried down IF/ID.
- i_id_pred_target  in  32  predicted target carried down IF/ID.
- o_id_mispredict  out  1  redirect IF and flush IF/ID.
- o_id_redirect_pc  out  32  correct next PC.
- o_stat_branches  out  32  resolved-branch count (see Configuration).
- o_stat_mispredicts  out  32  mispredict count (see Configuration).

## Operation
- Entry fields: valid, tag = pc[31:INDEX_BITS+2], target[31:0], ctr[CTR_BITS-1:0].
- Index = pc[INDEX_BITS+1:2]; pc[1:0] is ignored.
- Lookup (combinational): hit = valid && tag match.
  - o_if_predict_taken = hit && ctr[MSB].
  - o_if_pred_target = entry target, whether or not the lookup hits.
- Update enable: upd = i_id_valid && !i_stall.
- Mispredict: o_id_mispredict = upd && ((i_id_predicted != i_id_taken) || (i_id_predicted && i_id_taken && i_id_pred_target != i_id_target)).
- o_id_redirect_pc = i_id_taken ? i_id_target : i_id_pc + 4; 32-bit wrap, carry discarded.
- Training on upd, indexed by i_id_pc:
  - Hit, taken: ctr saturating-increments to 2^CTR_BITS−1 and target is rewritten.
  - Hit, not taken: ctr saturating-decrements to 0.
  - Miss, taken: allocate valid=1, tag, target, ctr = 2^(CTR_BITS−1) (weakly taken); any aliasing entry is overwritten.
  - Miss, not taken: no change.
- No state change when upd = 0.

## Timing
- Lookup and mispredict/redirect outputs are zero-latency combinational.
- Table writes take effect at the next rising edge.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents (no write-through bypass).
- Reset, synchronous:
  - All valid = 0.
  - All ctr = 2^(CTR_BITS−1)−1 (weakly not taken); targets = 0.
  - Stat counters = 0.
- Reset asserted in the same cycle as upd: reset wins and the update is lost.
- Outputs during and after reset:
  - o_if_predict_taken = 0 and o_if_pred_target = 0 for every PC.
  - o_id_mispredict and o_id_redirect_pc follow their inputs combinationally.
- CTR_BITS = 1: reset ctr = 0; allocation sets ctr = 1.

## Configuration
- BP_STATS_EN defined:
  - o_stat_branches increments on every upd.
  - o_stat_mispredicts increments on every upd with o_id_mispredict = 1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- BP_STATS_EN undefined: no counter registers are built, and both stat ports are tied to 0.

## Test plan
- Reset, then lookup 0x100 -> o_if_predict_taken 0, o_if_pred_target 0.
- Update 0x100 taken, target 0x200, predicted 0 -> mispredict 1, redirect 0x200; next cycle lookup 0x100 -> taken 1, target 0x200.
- From ctr 2: two not-taken updates -> lookup predicts 0, a third leaves ctr 0; then three taken updates -> ctr 3, and a fourth keeps it at 3.
- ENTRIES=64: after training 0x100 taken, lookup 0x200 (same index, different tag) -> 0; training 0x200 taken replaces the entry, and lookup 0x100 -> 0.
- i_id_valid=1 with i_stall=1, taken, predicted 0 -> mispredict 0 and table unchanged; same-cycle lookup of the updated index returns the old value.
- BP_STATS_EN: three updates with one mispredict -> stats 3/1; assert reset -> 0/0. Without the macro, both stat ports are always 0.
